// File: rtl/pe_mac_sequencer.sv
// pe_mac_sequencer: job controller for a single PE MAC unit.
// Streams operand pairs into the PE slot-major, strobes the rounder on each slot's
// last MAC and collects rounded results in a credit-protected result FIFO.
// Optional feature macro: PE_MAC_SEQUENCER_PERF_EN adds busy/stall cycle counters.
module pe_mac_sequencer #(
    parameter int unsigned  INT_BITS  = 7,
    parameter int unsigned  FRAC_BITS = 9,
    parameter int unsigned  LEN_W     = 8,
    parameter int unsigned  RES_DEPTH = 4,
    localparam int unsigned DW        = INT_BITS + FRAC_BITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [2:0]       cfg_slots_i,
    input  logic [LEN_W-1:0] cfg_len_i,
    output logic             busy_o,
    output logic             done_o,
    input  logic [DW-1:0]    src_a_i,
    input  logic [DW-1:0]    src_b_i,
    input  logic             src_valid_i,
    output logic             src_ready_o,
    output logic             pe_rst_n_o,
    output logic [DW-1:0]    pe_data_in_1_o,
    output logic [DW-1:0]    pe_data_in_2_o,
    output logic [3:0]       pe_add_number_o,
    output logic             pe_rounder_en_o,
    output logic             pe_keep_o,
    input  logic [DW-1:0]    pe_data_out_i,
    input  logic             pe_rounder_valid_i,
    input  logic [3:0]       pe_round_number_i,
    output logic [DW-1:0]    res_data_o,
    output logic [2:0]       res_slot_o,
    output logic             res_last_o,
    output logic             res_valid_o,
`ifdef PE_MAC_SEQUENCER_PERF_EN
    output logic [31:0]      perf_busy_cnt_o,
    output logic [31:0]      perf_stall_cnt_o,
`endif
    input  logic             res_ready_i
);

    localparam int unsigned PW = $clog2(RES_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] DepthFull = (CW + 1)'(RES_DEPTH);

    typedef enum logic [2:0] {StIdle, StClear, StRun, StDrain, StDone} state_e;

    state_e             state_q, state_d;
    logic [2:0]         cfg_slots_q, cfg_slots_d;
    logic [LEN_W-1:0]   cfg_len_q, cfg_len_d;
    logic [2:0]         slot_q, slot_d;
    logic [LEN_W-1:0]   mac_q, mac_d;
    logic               prot_q;
    logic [CW-1:0]      inflight_q, inflight_d;

    logic               cap_valid_q;
    logic [3:0]         cap_num_q;
    logic [DW-1:0]      cap_data_q;
    logic               cap_last;

    logic [DW-1:0]      data_mem_q [RES_DEPTH];
    logic [2:0]         slot_mem_q [RES_DEPTH];
    logic               last_mem_q [RES_DEPTH];
    logic [PW-1:0]      wr_q, rd_q;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic               run, slot_last, credit_zero, xfer, push, pop, keep_raw;
    logic [CW:0]        used;

    assign run         = (state_q == StRun);
    assign slot_last   = (mac_q == cfg_len_q);
    assign used        = {1'b0, cnt_q} + {1'b0, inflight_q};
    // Every slot-last MAC reserves one FIFO entry; stall it if none is free.
    assign credit_zero = (used >= DepthFull);
    assign src_ready_o = run && !(slot_last && credit_zero);
    assign xfer        = src_valid_i && src_ready_o;

    assign pe_rounder_en_o = xfer && slot_last;
    assign pe_data_in_1_o  = xfer ? src_a_i : '0;
    assign pe_data_in_2_o  = xfer ? src_b_i : '0;
    assign pe_add_number_o = {1'b0, slot_q};
    // Reset level is observed combinationally so outputs drop in the same cycle.
    assign pe_rst_n_o      = !rst && (state_q != StClear);
    assign pe_keep_o       = keep_raw && !rst;

    assign busy_o = (state_q != StIdle);
    assign done_o = (state_q == StDone);

    assign cap_last    = (cap_num_q == {1'b0, cfg_slots_q});
    assign push        = cap_valid_q && ((state_q == StRun) || (state_q == StDrain));
    assign res_valid_o = (cnt_q != '0);
    assign pop         = res_valid_o && res_ready_i;
    assign res_data_o  = data_mem_q[rd_q];
    assign res_slot_o  = slot_mem_q[rd_q];
    assign res_last_o  = last_mem_q[rd_q];

    // Next-state logic for the job FSM and the slot/MAC counters.
    always_comb begin
        state_d     = state_q;
        cfg_slots_d = cfg_slots_q;
        cfg_len_d   = cfg_len_q;
        slot_d      = slot_q;
        mac_d       = mac_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d     = StClear;
                    cfg_slots_d = cfg_slots_i;
                    cfg_len_d   = cfg_len_i;
                    slot_d      = '0;
                    mac_d       = '0;
                end
            end
            StClear: state_d = StRun;
            StRun: begin
                if (xfer) begin
                    if (slot_last) begin
                        mac_d = '0;
                        if (slot_q == cfg_slots_q) begin
                            slot_d  = '0;
                            state_d = StDrain;
                        end else begin
                            slot_d = slot_q + 3'd1;
                        end
                    end else begin
                        mac_d = mac_q + LEN_W'(1);
                    end
                end
            end
            StDrain: begin
                if (pop && res_last_o) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // PE freeze: bubbles freeze the pipeline, but the cycle after a round strobe must advance.
    always_comb begin
        keep_raw = 1'b1;
        unique case (state_q)
            StClear: keep_raw = 1'b0;
            StRun:   keep_raw = !xfer;
            default: keep_raw = 1'b1;
        endcase
        if (prot_q) begin
            keep_raw = 1'b0;
        end
    end

    // Results reserved but not yet captured: up on round strobe, down on FIFO push.
    always_comb begin
        inflight_d = inflight_q;
        if (pe_rounder_en_o && !push) begin
            inflight_d = inflight_q + CW'(1);
        end else if (!pe_rounder_en_o && push) begin
            inflight_d = inflight_q - CW'(1);
        end
    end

    // FIFO occupancy next-state.
    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!push && pop) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // FSM, counters, protected-cycle flag and credit state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cfg_slots_q <= '0;
            cfg_len_q   <= '0;
            slot_q      <= '0;
            mac_q       <= '0;
            prot_q      <= 1'b0;
            inflight_q  <= '0;
        end else begin
            state_q     <= state_d;
            cfg_slots_q <= cfg_slots_d;
            cfg_len_q   <= cfg_len_d;
            slot_q      <= slot_d;
            mac_q       <= mac_d;
            prot_q      <= pe_rounder_en_o;
            inflight_q  <= inflight_d;
        end
    end

    // One-cycle delay of the PE round stage before it is written to the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_valid_q <= 1'b0;
            cap_num_q   <= '0;
            cap_data_q  <= '0;
        end else begin
            cap_valid_q <= pe_rounder_valid_i;
            cap_num_q   <= pe_round_number_i;
            cap_data_q  <= pe_data_out_i;
        end
    end

    // Result FIFO storage and pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < RES_DEPTH; i++) begin
                data_mem_q[i] <= '0;
                slot_mem_q[i] <= '0;
                last_mem_q[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                data_mem_q[wr_q] <= cap_data_q;
                slot_mem_q[wr_q] <= cap_num_q[2:0];
                last_mem_q[wr_q] <= cap_last;
                wr_q             <= wr_q + PW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + PW'(1);
            end
            cnt_q <= cnt_d;
        end
    end

    // Credit accounting makes a push into a full FIFO impossible.
    assert property (@(posedge clk) disable iff (rst) !(push && !pop && ({1'b0, cnt_q} == DepthFull)));

`ifdef PE_MAC_SEQUENCER_PERF_EN
    logic [31:0] perf_busy_q, perf_stall_q;

    // Busy and stall cycle counters: restart on job acceptance, saturate at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
        end else if ((state_q == StIdle) && start_i) begin
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if (busy_o && (perf_busy_q != '1)) begin
                perf_busy_q <= perf_busy_q + 32'd1;
            end
            if (run && pe_keep_o && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_busy_cnt_o  = perf_busy_q;
    assign perf_stall_cnt_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_pe_mac_sequencer.sv
// Testbench for pe_mac_sequencer: behavioural PE model, randomized jobs, and a
// scoreboard that predicts each slot's rounded sum of products.
module tb_pe_mac_sequencer;

    localparam int DW   = 16;
    localparam int FRAC = 9;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [2:0]      cfg_slots;
    logic [7:0]      cfg_len;
    logic            busy, done;
    logic [DW-1:0]   src_a, src_b;
    logic            src_valid, src_ready;
    logic            pe_rst_n;
    logic [DW-1:0]   pe_data_in_1, pe_data_in_2;
    logic [3:0]      pe_add_number;
    logic            pe_rounder_en, pe_keep;
    logic [DW-1:0]   pe_data_out = '0;
    logic            pe_rounder_valid = 1'b0;
    logic [3:0]      pe_round_number = '0;
    logic [DW-1:0]   res_data;
    logic [2:0]      res_slot;
    logic            res_last, res_valid;
    logic            res_ready;
`ifdef PE_MAC_SEQUENCER_PERF_EN
    logic [31:0]     perf_busy_cnt, perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    pe_mac_sequencer #(
        .INT_BITS (7),
        .FRAC_BITS(9),
        .LEN_W    (8),
        .RES_DEPTH(4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .start_i           (start),
        .cfg_slots_i       (cfg_slots),
        .cfg_len_i         (cfg_len),
        .busy_o            (busy),
        .done_o            (done),
        .src_a_i           (src_a),
        .src_b_i           (src_b),
        .src_valid_i       (src_valid),
        .src_ready_o       (src_ready),
        .pe_rst_n_o        (pe_rst_n),
        .pe_data_in_1_o    (pe_data_in_1),
        .pe_data_in_2_o    (pe_data_in_2),
        .pe_add_number_o   (pe_add_number),
        .pe_rounder_en_o   (pe_rounder_en),
        .pe_keep_o         (pe_keep),
        .pe_data_out_i     (pe_data_out),
        .pe_rounder_valid_i(pe_rounder_valid),
        .pe_round_number_i (pe_round_number),
        .res_data_o        (res_data),
        .res_slot_o        (res_slot),
        .res_last_o        (res_last),
        .res_valid_o       (res_valid),
`ifdef PE_MAC_SEQUENCER_PERF_EN
        .perf_busy_cnt_o   (perf_busy_cnt),
        .perf_stall_cnt_o  (perf_stall_cnt),
`endif
        .res_ready_i       (res_ready)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int xfer_cnt = 0;
    int t_last   = 0;
    int rr_mode  = 0;

    typedef struct {
        logic [DW-1:0] data;
        int            slot;
        bit            last;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Round-to-nearest of a Q.(2*FRAC) sum back to the Q.FRAC word.
    function automatic logic [DW-1:0] rnd(input longint s);
        longint r;
        r = (s + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
        return r[DW-1:0];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // PE model: stage 1 multiplies, stage 2 accumulates and rounds; keep freezes both.
    longint     acc [8];
    longint     m_prod = 0;
    logic [3:0] m_num  = '0;
    logic       m_round = 1'b0, m_vld = 1'b0;
    always @(posedge clk) begin
        if (!pe_rst_n) begin
            for (int i = 0; i < 8; i++) acc[i] <= 0;
            m_vld            <= 1'b0;
            m_round          <= 1'b0;
            m_prod           <= 0;
            pe_rounder_valid <= 1'b0;
        end else begin
            pe_rounder_valid <= 1'b0;
            if (!pe_keep) begin
                if (m_vld) begin
                    acc[m_num[2:0]] <= acc[m_num[2:0]] + m_prod;
                    if (m_round) begin
                        pe_rounder_valid <= 1'b1;
                        pe_round_number  <= m_num;
                        pe_data_out      <= rnd(acc[m_num[2:0]] + m_prod);
                    end
                end
                m_prod  <= longint'($signed(pe_data_in_1)) * longint'($signed(pe_data_in_2));
                m_num   <= pe_add_number;
                m_round <= pe_rounder_en;
                m_vld   <= 1'b1;
            end
        end
    end

    // Result consumer readiness.
    initial begin
        res_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                0:       res_ready = 1'b1;
                1:       res_ready = ($urandom_range(3) != 0);
                default: res_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every accepted result, checks done timing.
    initial begin
        bit   done_pending;
        exp_t e;
        done_pending = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                done_pending = 0;
            end else begin
                if (done_pending) begin
                    check("done_after_last_pop", done, 1);
                    done_pending = 0;
                end else if (done) begin
                    check("done_unexpected", done, 0);
                end
                if (res_valid && res_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL result_unexpected: got data 0x%0h slot %0d, expected none",
                                 res_data, res_slot);
                    end else begin
                        e = exp_q.pop_front();
                        check("res_data", res_data, e.data);
                        check("res_slot", res_slot, e.slot);
                        check("res_last", res_last, e.last);
                        if (e.last) done_pending = 1;
                    end
                end
            end
        end
    end

    // opmode 0: random operands; 1: 0x0200*0x0200; 2: 0x0200*((slot+1)<<9).
    task automatic run_job(input int slots, input int len, input int opmode, input int vmode,
                           input int bub_at, input int bub_len, input bit chk_keep,
                           input int max_xfer);
        logic [DW-1:0] qa[$];
        logic [DW-1:0] qb[$];
        logic [DW-1:0] a, b;
        longint        sum;
        exp_t          e;
        bit            sent;
        for (int s = 0; s <= slots; s++) begin
            sum = 0;
            for (int m = 0; m <= len; m++) begin
                case (opmode)
                    1:       begin a = 16'h0200; b = 16'h0200; end
                    2:       begin a = 16'h0200; b = DW'((s + 1) << 9); end
                    default: begin a = DW'($urandom); b = DW'($urandom); end
                endcase
                qa.push_back(a);
                qb.push_back(b);
                sum += longint'($signed(a)) * longint'($signed(b));
            end
            e.data = rnd(sum);
            e.slot = s;
            e.last = (s == slots);
            exp_q.push_back(e);
        end
        xfer_cnt  = 0;
        cfg_slots = 3'(slots);
        cfg_len   = 8'(len);
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("clear_pe_rst_n", pe_rst_n, 0);
        check("busy_after_start", busy, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("run_pe_rst_n", pe_rst_n, 1);
        @(posedge clk);
        #1;
        for (int idx = 0; idx < qa.size() && idx < max_xfer; idx++) begin
            if (idx == bub_at) begin
                for (int k = 0; k < bub_len; k++) begin
                    src_valid = 1'b0;
                    @(negedge clk);
                    if (chk_keep) check("bubble_pe_keep", pe_keep, 1);
                    @(posedge clk);
                    #1;
                end
            end
            src_a = qa[idx];
            src_b = qb[idx];
            sent  = 0;
            for (int w = 0; w < 400 && !sent; w++) begin
                src_valid = (vmode == 0) ? 1'b1 : ($urandom_range(9) < 7);
                @(negedge clk);
                if (src_valid && src_ready) begin
                    sent = 1;
                    xfer_cnt++;
                    t_last = cyc;
                end
                @(posedge clk);
                #1;
            end
            if (!sent) begin
                check("operand_accept_timeout", sent, 1);
                break;
            end
        end
        src_valid = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        bit seen;
        seen = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        check("job_done_seen", seen, 1);
        @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_src_ready"}, src_ready, 0);
        check({tag, "_pe_rst_n"}, pe_rst_n, 0);
        check({tag, "_pe_keep"}, pe_keep, 0);
        check({tag, "_pe_rounder_en"}, pe_rounder_en, 0);
        check({tag, "_pe_data_in"}, {pe_data_in_1, pe_data_in_2}, 0);
        check({tag, "_pe_add_number"}, pe_add_number, 0);
        check({tag, "_res_valid"}, res_valid, 0);
    endtask

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: got still running, expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        rst       = 1'b1;
        start     = 1'b0;
        cfg_slots = '0;
        cfg_len   = '0;
        src_a     = '0;
        src_b     = '0;
        src_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single slot, four MACs of 1.0*1.0; result latency and done timing.
        run_job(0, 3, 1, 0, -1, 0, 0, 1000);
        found = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge clk);
            if (res_valid) begin
                found = 1;
                check("res_valid_latency", cyc - t_last, 4);
            end
        end
        check("res_valid_seen", found, 1);
        wait_done(50);

        // Eight single-MAC slots, results 0x0200..0x1000 in slot order.
        run_job(7, 0, 2, 0, -1, 0, 0, 1000);
        wait_done(100);

        // Three-cycle operand bubble mid-slot freezes the PE; sum unchanged.
        run_job(0, 3, 1, 0, 2, 3, 1, 1000);
        wait_done(50);

        // Consumer stalled: only four slot-lasts may issue before credit runs out.
        rr_mode = 2;
        @(posedge clk);
        #1;
        fork
            run_job(7, 0, 0, 0, -1, 0, 0, 1000);
            begin
                repeat (30) @(negedge clk);
                check("credit_xfers", xfer_cnt, 4);
                check("credit_src_ready", src_ready, 0);
                rr_mode = 0;
            end
        join
        wait_done(200);

        // Back-to-back jobs: the second slot-0 sum must not carry the first.
        run_job(0, 2, 0, 0, -1, 0, 0, 1000);
        wait_done(50);
        run_job(0, 2, 0, 0, -1, 0, 0, 1000);
        wait_done(50);

        // Reset in the middle of RUN, then a clean job.
        run_job(7, 3, 0, 0, -1, 0, 0, 10);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrun_reset");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_job(2, 2, 0, 1, -1, 0, 0, 1000);
        wait_done(300);

        // Random jobs with random operand bubbles and consumer back-pressure.
        rr_mode = 1;
        for (int j = 0; j < 6; j++) begin
            run_job(int'($urandom_range(7)), int'($urandom_range(5)), 0, 1, -1, 0, 0, 1000);
            wait_done(1000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
